// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared types and encodings for the cache/RAM arbiter.
package cache_mem_arbiter_pkg;
  typedef logic [31:0] word_t;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DGRANT = 2'd1;
  localparam logic [1:0] IGRANT = 2'd2;
  localparam logic INSTR = 1'b0;
  localparam logic DATA  = 1'b1;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: cache request and RAM port bundle; slave is the arbiter side.
interface cache_mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin arbiter between icache and dcache onto a single RAM port.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  cache_mem_arbiter_if.slave  bus,
  output logic [ERRCNT_W-1:0] err_count
);
  logic [1:0] st, nxt;
  logic last_grant, d_req, i_req, acc, grant_d, grant_i;
  always_comb begin
    d_req   = bus.dREN | bus.dWEN;
    i_req   = bus.iREN;
    acc     = bus.ramstate == ACCESS;
    grant_d = st == DGRANT && d_req;
    grant_i = st == IGRANT && i_req;
    nxt = st == IDLE ? (d_req && i_req ? (last_grant == INSTR ? DGRANT : IGRANT) :
                        d_req ? DGRANT : i_req ? IGRANT : IDLE) :
          (grant_d || grant_i) && !acc ? st : IDLE;
    // a withdrawn request drops the RAM enables in the same cycle
    bus.ramWEN   = grant_d && bus.dWEN;
    bus.ramREN   = (grant_d && !bus.dWEN) || grant_i;
    bus.ramaddr  = st == DGRANT ? bus.daddr : st == IGRANT ? bus.iaddr : {ADDR_W{1'b0}};
    bus.ramstore = bus.ramWEN ? bus.dstore : {DATA_W{1'b0}};
    bus.dload    = st == DGRANT ? bus.ramload : {DATA_W{1'b0}};
    bus.iload    = st == IGRANT ? bus.ramload : {DATA_W{1'b0}};
    bus.dwait    = !(grant_d && acc);
    bus.iwait    = !(grant_i && acc);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st         <= IDLE;
      last_grant <= INSTR;
      err_count  <= '0;
    end else begin
      st <= nxt;
      if (grant_d && acc) last_grant <= DATA;
      else if (grant_i && acc) last_grant <= INSTR;
      if ((bus.ramREN || bus.ramWEN) && bus.ramstate == ERROR && !(&err_count))
        err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed checks of arbitration, completion, error retry and abort.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [7:0] err_count;
  int n_checks = 0;
  int n_fail = 0;
  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ERRCNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .err_count(err_count)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic settle();
    #3;
  endtask
  initial begin
    word_t rd;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
    #2;
    check("rst_iwait", bus.iwait, 1);
    check("rst_dwait", bus.dwait, 1);
    check("rst_ramren", bus.ramREN, 0);
    check("rst_ramwen", bus.ramWEN, 0);
    check("rst_errcnt", err_count, 0);
    step(); step();
    RST = 0;
    step(); step();
    settle();
    check("idle_ramren", bus.ramREN, 0);
    check("idle_ramaddr", bus.ramaddr, 0);
    // instruction read with two BUSY cycles
    bus.iREN = 1; bus.iaddr = 32'h100; bus.ramstate = BUSY;
    settle();
    check("ird_req_cycle_ren", bus.ramREN, 0);
    check("ird_req_cycle_iwait", bus.iwait, 1);
    step(); settle();
    check("ird_ren", bus.ramREN, 1);
    check("ird_addr", bus.ramaddr, 32'h100);
    check("ird_busy1_iwait", bus.iwait, 1);
    step(); settle();
    check("ird_busy2_iwait", bus.iwait, 1);
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    settle();
    check("ird_acc_iwait", bus.iwait, 0);
    check("ird_acc_iload", bus.iload, 32'hDEADBEEF);
    check("ird_acc_dwait", bus.dwait, 1);
    check("ird_acc_dload", bus.dload, 0);
    step();
    bus.iREN = 0; bus.ramstate = FREE;
    settle();
    check("ird_after_iwait", bus.iwait, 1);
    check("ird_after_iload", bus.iload, 0);
    check("ird_after_ren", bus.ramREN, 0);
    // data write, RAM accepts immediately
    bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h12345678; bus.ramstate = ACCESS;
    settle();
    check("dwr_req_cycle_dwait", bus.dwait, 1);
    check("dwr_req_cycle_wen", bus.ramWEN, 0);
    step(); settle();
    check("dwr_wen", bus.ramWEN, 1);
    check("dwr_ren", bus.ramREN, 0);
    check("dwr_addr", bus.ramaddr, 32'h200);
    check("dwr_store", bus.ramstore, 32'h12345678);
    check("dwr_dwait", bus.dwait, 0);
    check("dwr_iwait", bus.iwait, 1);
    // async reset mid-transaction, then contention from reset
    bus.dWEN = 0; bus.dREN = 1; bus.iREN = 1;
    bus.daddr = 32'h300; bus.iaddr = 32'h400; bus.ramload = 32'hA5A5_0001;
    RST = 1;
    #1;
    check("async_rst_wen", bus.ramWEN, 0);
    check("async_rst_ren", bus.ramREN, 0);
    check("async_rst_dwait", bus.dwait, 1);
    step();
    RST = 0;
    settle();
    check("cont_idle_ren", bus.ramREN, 0);
    for (int k = 0; k < 4; k++) begin
      step(); settle();
      check($sformatf("cont%0d_dwait", k), bus.dwait, (k % 2 == 0) ? 1'b0 : 1'b1);
      check($sformatf("cont%0d_iwait", k), bus.iwait, (k % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("cont%0d_addr", k), bus.ramaddr, (k % 2 == 0) ? 32'h300 : 32'h400);
      check($sformatf("cont%0d_load", k), (k % 2 == 0) ? bus.dload : bus.iload, 32'hA5A5_0001);
      step(); settle();
      check($sformatf("cont%0d_gap_ren", k), bus.ramREN, 0);
    end
    // error retry on a data read
    bus.iREN = 0; bus.ramstate = ERROR;
    for (int k = 0; k < 3; k++) begin
      step(); settle();
      check($sformatf("err%0d_dwait", k), bus.dwait, 1);
      check($sformatf("err%0d_ren", k), bus.ramREN, 1);
    end
    step();
    bus.ramstate = ACCESS;
    settle();
    check("err_count3", err_count, 3);
    check("err_done_dwait", bus.dwait, 0);
    step();
    bus.ramstate = ERROR;
    for (int k = 0; k < 300; k++) step();
    settle();
    check("err_sat", err_count, 255);
    check("err_sat_dwait", bus.dwait, 1);
    bus.ramstate = ACCESS;
    settle();
    check("err_sat_done_dwait", bus.dwait, 0);
    step();
    bus.dREN = 0; bus.ramstate = BUSY;
    settle();
    check("err_sat_hold", err_count, 255);
    // abort: I granted (last grant was data), then iREN withdrawn
    bus.iREN = 1; bus.dREN = 1; bus.iaddr = 32'h500; bus.daddr = 32'h600;
    step(); settle();
    check("abort_grant_addr", bus.ramaddr, 32'h500);
    check("abort_grant_ren", bus.ramREN, 1);
    bus.iREN = 0;
    #1;
    check("abort_drop_ren", bus.ramREN, 0);
    check("abort_drop_iwait", bus.iwait, 1);
    step(); settle();
    check("abort_idle_ren", bus.ramREN, 0);
    check("abort_idle_iwait", bus.iwait, 1);
    step(); settle();
    check("abort_dgrant_ren", bus.ramREN, 1);
    check("abort_dgrant_addr", bus.ramaddr, 32'h600);
    bus.dWEN = 1; bus.dstore = 32'hCAFE_F00D;
    #1;
    check("rw_both_wen", bus.ramWEN, 1);
    check("rw_both_ren", bus.ramREN, 0);
    check("rw_both_store", bus.ramstore, 32'hCAFE_F00D);
    rd = bus.ramaddr;
    check("rw_both_addr", rd, 32'h600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
